// File: rtl/dsp_casc_pkg.sv
// Shared types for the cascaded multiply-accumulate slice.
package dsp_casc_pkg;

    localparam int unsigned OPMODE_W = 6;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_C    = 2'd3
    } xsel_e;

    typedef enum logic [2:0] {
        Z_ZERO    = 3'd0,
        Z_PCIN    = 3'd1,
        Z_P       = 3'd2,
        Z_C       = 3'd3,
        Z_PCIN_SH = 3'd5,
        Z_P_SH    = 3'd6
    } zsel_e;

    // zsel is kept as raw bits: codes 4 and 7 are legal on the bus and select zero.
    typedef struct packed {
        logic        sub;
        logic [2:0]  zsel;
        xsel_e       xsel;
    } opmode_t;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Async-reset delay line with a shared load enable; DEPTH=0 degenerates to a wire.
module dsp_pipe_reg #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign q = d;
    end else begin : g_regs
        logic [W-1:0] stage [DEPTH];

        // Shift the whole line forward on every enabled edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/dsp_casc_mac.sv
// One cascadable multiply-accumulate slice:
// A/B -> ABREG stages -> multiply -> MREG stages -> X/Z select -> add/sub -> P register.
module dsp_casc_mac
    import dsp_casc_pkg::*;
#(
    parameter int unsigned A_W        = 17,
    parameter int unsigned B_W        = 17,
    parameter int unsigned C_W        = 34,
    parameter int unsigned P_W        = 48,
    parameter int unsigned OUT_W      = 34,
    parameter int unsigned ABREG      = 1,
    parameter int unsigned MREG       = 1,
    parameter int unsigned CREG       = 1,
    parameter int unsigned SHIFT      = 17,
    parameter int unsigned CTRL_ALIGN = 0
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                valid_i,
    input  logic                CREG_en_i,
    input  logic [OPMODE_W-1:0] OPMODE_i,
    input  logic [A_W-1:0]      A_i,
    input  logic [B_W-1:0]      B_i,
    input  logic [C_W-1:0]      C_i,
    input  logic [P_W-1:0]      PCIN_i,
    output logic [OUT_W-1:0]    P_o,
    output logic [P_W-1:0]      PCOUT_o,
    output logic                valid_o
);

    localparam int unsigned LAT      = 1 + ABREG + MREG;
    localparam int unsigned M_W      = A_W + B_W;
    // Aligned control rides with the operands; otherwise a single register like the hard slice.
    localparam int unsigned OP_DEPTH = (CTRL_ALIGN != 0) ? LAT - 1 : 1;

    if (P_W < A_W + B_W + 1) begin : g_chk_pw
        $error("dsp_casc_mac: P_W must be at least A_W+B_W+1");
    end
    if (OUT_W > P_W) begin : g_chk_outw
        $error("dsp_casc_mac: OUT_W must not exceed P_W");
    end
    if (ABREG > 2 || MREG > 1 || CREG > 1) begin : g_chk_depth
        $error("dsp_casc_mac: register depth parameter out of range");
    end

    logic [M_W-1:0]      ab_pipe;
    logic [A_W-1:0]      a_pipe;
    logic [B_W-1:0]      b_pipe;
    logic [M_W-1:0]      m_raw;
    logic [M_W-1:0]      m_pipe;
    logic [C_W-1:0]      c_pipe;
    logic [OPMODE_W-1:0] op_raw;
    opmode_t             op;
    logic [P_W-1:0]      m_ext;
    logic [P_W-1:0]      c_ext;
    logic [P_W-1:0]      x_val;
    logic [P_W-1:0]      z_val;
    logic [P_W-1:0]      p_next;
    logic [P_W-1:0]      p_reg;

    dsp_pipe_reg #(.W(M_W), .DEPTH(ABREG)) u_ab_pipe (
        .clk (clock_i),
        .rst (reset_i),
        .en  (1'b1),
        .d   ({A_i, B_i}),
        .q   (ab_pipe)
    );

    assign a_pipe = ab_pipe[M_W-1:B_W];
    assign b_pipe = ab_pipe[B_W-1:0];
    assign m_raw  = M_W'(a_pipe) * M_W'(b_pipe);

    dsp_pipe_reg #(.W(M_W), .DEPTH(MREG)) u_m_pipe (
        .clk (clock_i),
        .rst (reset_i),
        .en  (1'b1),
        .d   (m_raw),
        .q   (m_pipe)
    );

    dsp_pipe_reg #(.W(C_W), .DEPTH(CREG)) u_c_pipe (
        .clk (clock_i),
        .rst (reset_i),
        .en  (CREG_en_i),
        .d   (C_i),
        .q   (c_pipe)
    );

    dsp_pipe_reg #(.W(OPMODE_W), .DEPTH(OP_DEPTH)) u_op_pipe (
        .clk (clock_i),
        .rst (reset_i),
        .en  (1'b1),
        .d   (OPMODE_i),
        .q   (op_raw)
    );

    dsp_pipe_reg #(.W(1), .DEPTH(LAT)) u_valid_pipe (
        .clk (clock_i),
        .rst (reset_i),
        .en  (1'b1),
        .d   (valid_i),
        .q   (valid_o)
    );

    assign op    = opmode_t'(op_raw);
    assign m_ext = P_W'(m_pipe);
    assign c_ext = P_W'(c_pipe);

    // Select the X and Z adder operands and form the wrapping sum or difference.
    always_comb begin
        x_val = '0;
        case (op.xsel)
            X_ZERO:  x_val = '0;
            X_M:     x_val = m_ext;
            X_P:     x_val = p_reg;
            X_C:     x_val = c_ext;
            default: x_val = '0;
        endcase

        z_val = '0;
        case (op.zsel)
            Z_PCIN:    z_val = PCIN_i;
            Z_P:       z_val = p_reg;
            Z_C:       z_val = c_ext;
            Z_PCIN_SH: z_val = PCIN_i >> SHIFT;
            Z_P_SH:    z_val = p_reg >> SHIFT;
            default:   z_val = '0;
        endcase

        p_next = op.sub ? (z_val - x_val) : (z_val + x_val);
    end

    // Accumulator updates on every edge; valid only tags the result, it gates nothing.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) p_reg <= '0;
        else         p_reg <= p_next;
    end

    assign P_o     = p_reg[OUT_W-1:0];
    assign PCOUT_o = p_reg;

endmodule

// File: tb/tb_dsp_casc_mac.sv
// Bench for dsp_casc_mac: twelve configurations (ABREG x MREG x CTRL_ALIGN) share one
// stimulus stream and are checked each cycle against an input-history model; a second
// slice cascades off the default configuration.
module tb_dsp_casc_mac;

    localparam int NCFG = 12;
    localparam int DEF  = 10;  // ABREG=1, MREG=1, CTRL_ALIGN=1

    logic        clk;
    logic        rst;
    logic        vin;
    logic        cen;
    logic [5:0]  op;
    logic [16:0] a;
    logic [16:0] b;
    logic [33:0] c;
    logic [47:0] pcin;

    logic [33:0] po_a [NCFG];
    logic [47:0] pc_a [NCFG];
    logic        vo_a [NCFG];

    logic [33:0] s1_po;
    logic [47:0] s1_pc;
    logic        s1_vo;

    int total;
    int bad;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        dsp_casc_mac #(
            .ABREG      (g % 3),
            .MREG       ((g / 3) % 2),
            .CTRL_ALIGN (g / 6)
        ) u_dut (
            .clock_i   (clk),
            .reset_i   (rst),
            .valid_i   (vin),
            .CREG_en_i (cen),
            .OPMODE_i  (op),
            .A_i       (a),
            .B_i       (b),
            .C_i       (c),
            .PCIN_i    (pcin),
            .P_o       (po_a[g]),
            .PCOUT_o   (pc_a[g]),
            .valid_o   (vo_a[g])
        );
    end

    // Downstream slice: Z = PCIN >> 17, X = 0, control passed straight through.
    dsp_casc_mac #(
        .ABREG      (0),
        .MREG       (0),
        .CTRL_ALIGN (1)
    ) u_slice1 (
        .clock_i   (clk),
        .reset_i   (rst),
        .valid_i   (1'b0),
        .CREG_en_i (1'b0),
        .OPMODE_i  (6'b010100),
        .A_i       (17'd0),
        .B_i       (17'd0),
        .C_i       (34'd0),
        .PCIN_i    (pc_a[DEF]),
        .P_o       (s1_po),
        .PCOUT_o   (s1_pc),
        .valid_o   (s1_vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // h_*[k] holds the inputs seen k+1 edges ago; index d=0 means "this edge".
    logic [16:0] h_a  [3];
    logic [16:0] h_b  [3];
    logic [5:0]  h_op [3];
    logic        h_v  [3];
    logic [47:0] mp   [NCFG];
    logic        mv   [NCFG];
    logic [47:0] mc;
    logic [47:0] mp1;

    function automatic logic [16:0] a_at(int d);
        return (d == 0) ? a : h_a[d-1];
    endfunction
    function automatic logic [16:0] b_at(int d);
        return (d == 0) ? b : h_b[d-1];
    endfunction
    function automatic logic [5:0] op_at(int d);
        return (d == 0) ? op : h_op[d-1];
    endfunction
    function automatic logic v_at(int d);
        return (d == 0) ? vin : h_v[d-1];
    endfunction

    function automatic logic [47:0] alu(logic [5:0] o, logic [47:0] m, logic [47:0] p,
                                        logic [47:0] cv, logic [47:0] pc);
        logic [47:0] x;
        logic [47:0] z;
        x = (o[1:0] == 2'd1) ? m : (o[1:0] == 2'd2) ? p : (o[1:0] == 2'd3) ? cv : 48'd0;
        z = (o[4:2] == 3'd1) ? pc : (o[4:2] == 3'd2) ? p : (o[4:2] == 3'd3) ? cv :
            (o[4:2] == 3'd5) ? (pc >> 17) : (o[4:2] == 3'd6) ? (p >> 17) : 48'd0;
        return o[5] ? z - x : z + x;
    endfunction

    function automatic logic [47:0] next_p(int g);
        int dm;
        int dop;
        logic [47:0] m;
        dm  = (g % 3) + ((g / 3) % 2);
        dop = (g / 6 != 0) ? dm : 1;
        m   = 48'(a_at(dm)) * 48'(b_at(dm));
        return alu(op_at(dop), m, mp[g], mc, pcin);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NCFG; g++) begin
                mp[g] <= '0;
                mv[g] <= 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                h_a[k]  <= '0;
                h_b[k]  <= '0;
                h_op[k] <= '0;
                h_v[k]  <= 1'b0;
            end
            mc  <= '0;
            mp1 <= '0;
        end else begin
            for (int g = 0; g < NCFG; g++) begin
                mp[g] <= next_p(g);
                mv[g] <= v_at((g % 3) + ((g / 3) % 2));
            end
            mp1 <= mp[DEF] >> 17;
            if (cen) mc <= 48'(c);
            h_a[0]  <= a;   h_a[1]  <= h_a[0];  h_a[2]  <= h_a[1];
            h_b[0]  <= b;   h_b[1]  <= h_b[0];  h_b[2]  <= h_b[1];
            h_op[0] <= op;  h_op[1] <= h_op[0]; h_op[2] <= h_op[1];
            h_v[0]  <= vin; h_v[1]  <= h_v[0];  h_v[2]  <= h_v[1];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("cfg%0d_pcout", g), 64'(pc_a[g]), 64'(mp[g]));
            check($sformatf("cfg%0d_p", g), 64'(po_a[g]), 64'(mp[g][33:0]));
            check($sformatf("cfg%0d_valid", g), 64'(vo_a[g]), 64'(mv[g]));
        end
        check("slice1_pcout", 64'(s1_pc), 64'(mp1));
    endtask

    // One clock: sample #1 after the edge, then compare every configuration.
    task automatic tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_in(input logic v, input logic ce, input logic [5:0] o,
                          input logic [16:0] aa, input logic [16:0] bb, input logic [33:0] cc);
        vin  = v;
        cen  = ce;
        op   = o;
        a    = aa;
        b    = bb;
        c    = cc;
        pcin = '0;
    endtask

    localparam logic [5:0] OP_M     = 6'b000001;  // X=M, Z=0
    localparam logic [5:0] OP_M_P   = 6'b001001;  // X=M, Z=P
    localparam logic [5:0] OP_C     = 6'b000011;  // X=C, Z=0
    localparam logic [5:0] OP_C_SUB = 6'b100011;  // 0 - C

    int vcount;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_in(1'b0, 1'b0, 6'd0, 17'd0, 17'd0, 34'd0);
        tick();
        tick();
        check("reset_p", 64'(po_a[DEF]), 64'd0);
        check("reset_valid", 64'(vo_a[DEF]), 64'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Single multiply: result and valid appear LAT=3 edges after the operands.
        set_in(1'b1, 1'b0, OP_M, 17'd3, 17'd5, 34'd0);
        tick();
        set_in(1'b0, 1'b0, 6'd0, 17'd0, 17'd0, 34'd0);
        tick();
        check("mul_valid_early", 64'(vo_a[DEF]), 64'd0);
        tick();
        check("mul_p", 64'(po_a[DEF]), 64'd15);
        check("mul_valid", 64'(vo_a[DEF]), 64'd1);
        repeat (2) tick();

        // Accumulate chain.
        set_in(1'b1, 1'b0, OP_M, 17'd1, 17'd2, 34'd0);
        tick();
        set_in(1'b1, 1'b0, OP_M_P, 17'd3, 17'd4, 34'd0);
        tick();
        set_in(1'b1, 1'b0, OP_M_P, 17'd5, 17'd6, 34'd0);
        tick();
        check("acc_0", 64'(po_a[DEF]), 64'd2);
        set_in(1'b0, 1'b0, 6'd0, 17'd0, 17'd0, 34'd0);
        tick();
        check("acc_1", 64'(po_a[DEF]), 64'd14);
        tick();
        check("acc_2", 64'(po_a[DEF]), 64'd44);
        repeat (2) tick();

        // Cascade: load P from C, downstream slice shows PCIN>>17 one edge later.
        set_in(1'b0, 1'b1, 6'd0, 17'd0, 17'd0, 34'h3_0001_2345);
        tick();
        set_in(1'b0, 1'b0, OP_C, 17'd0, 17'd0, 34'd0);
        tick();
        set_in(1'b0, 1'b0, 6'd0, 17'd0, 17'd0, 34'd0);
        tick();
        tick();
        check("casc_slice0", 64'(pc_a[DEF]), 64'h3_0001_2345);
        tick();
        check("casc_slice1", 64'(s1_pc), 64'h1_8000);
        repeat (2) tick();

        // Subtract wrap: 0 - 1.
        set_in(1'b0, 1'b1, 6'd0, 17'd0, 17'd0, 34'd1);
        tick();
        set_in(1'b0, 1'b0, OP_C_SUB, 17'd0, 17'd0, 34'd0);
        tick();
        set_in(1'b0, 1'b0, 6'd0, 17'd0, 17'd0, 34'd0);
        tick();
        tick();
        check("sub_pcout", 64'(pc_a[DEF]), 64'hFFFF_FFFF_FFFF);
        check("sub_p", 64'(po_a[DEF]), 64'h3_FFFF_FFFF);
        repeat (2) tick();

        // Reset mid-flight: in-flight operations must vanish without a valid_o.
        set_in(1'b1, 1'b0, OP_M, 17'd7, 17'd9, 34'd0);
        tick();
        set_in(1'b1, 1'b0, OP_M, 17'd8, 17'd9, 34'd0);
        tick();
        #1 rst = 1'b1;
        #1;
        check("rst_mid_pcout", 64'(pc_a[DEF]), 64'd0);
        check("rst_mid_p", 64'(po_a[DEF]), 64'd0);
        check("rst_mid_valid", 64'(vo_a[DEF]), 64'd0);
        set_in(1'b1, 1'b0, OP_M, 17'd9, 17'd9, 34'd0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 6'd0, 17'd0, 17'd0, 34'd0);
        vcount = 0;
        repeat (4) begin
            tick();
            vcount += int'(vo_a[DEF]);
        end
        check("rst_no_valid", 64'(vcount), 64'd0);
        set_in(1'b1, 1'b0, OP_M, 17'd11, 17'd13, 34'd0);
        tick();
        set_in(1'b0, 1'b0, 6'd0, 17'd0, 17'd0, 34'd0);
        tick();
        tick();
        check("rst_after_p", 64'(po_a[DEF]), 64'd143);
        check("rst_after_valid", 64'(vo_a[DEF]), 64'd1);

        // Random sweep across all configurations, with one reset pulse in the middle.
        for (int i = 0; i < 1000; i++) begin
            vin  = 1'($urandom());
            cen  = 1'($urandom());
            op   = 6'($urandom());
            a    = 17'($urandom());
            b    = 17'($urandom());
            c    = 34'({$urandom(), $urandom()});
            pcin = 48'({$urandom(), $urandom()});
            if (i == 500) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
